// File: rtl/clock_display_pkg.sv
// Shared types, 7-segment glyph constants and the digit encoder for the
// MM:SS multiplexed display driver.
package clock_display_pkg;

  typedef logic [1:0] digit_idx_t;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIGIT_DASH = 4'hF;

  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:       glyph = SEG_0;
      4'd1:       glyph = SEG_1;
      4'd2:       glyph = SEG_2;
      4'd3:       glyph = SEG_3;
      4'd4:       glyph = SEG_4;
      4'd5:       glyph = SEG_5;
      4'd6:       glyph = SEG_6;
      4'd7:       glyph = SEG_7;
      4'd8:       glyph = SEG_8;
      4'd9:       glyph = SEG_9;
      DIGIT_DASH: glyph = SEG_DASH;
      default:    glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/bin60_to_bcd.sv
// Splits a 0..59 binary value into tens/ones digits with a compare chain
// instead of a divider; values above 59 are flagged invalid.
module bin60_to_bcd
  import clock_display_pkg::*;
(
  input  logic [5:0] value_i,
  output logic [2:0] tens_o,
  output logic [3:0] ones_o,
  output logic       invalid_o
);

  always_comb begin
    invalid_o = (value_i > 6'd59);
    tens_o    = 3'd0;
    ones_o    = value_i[3:0];
    // Digits are don't-care when invalid; the caller substitutes a dash.
    if (value_i >= 6'd50) begin
      tens_o = 3'd5;
      ones_o = 4'(value_i - 6'd50);
    end else if (value_i >= 6'd40) begin
      tens_o = 3'd4;
      ones_o = 4'(value_i - 6'd40);
    end else if (value_i >= 6'd30) begin
      tens_o = 3'd3;
      ones_o = 4'(value_i - 6'd30);
    end else if (value_i >= 6'd20) begin
      tens_o = 3'd2;
      ones_o = 4'(value_i - 6'd20);
    end else if (value_i >= 6'd10) begin
      tens_o = 3'd1;
      ones_o = 4'(value_i - 6'd10);
    end
  end

endmodule

// File: rtl/clock_display_driver.sv
// Scans a 4-digit multiplexed 7-segment display as MM:SS, using one input
// snapshot per frame so a frame never mixes two different times.
module clock_display_driver
  import clock_display_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [RC_W-1:0] rc_q;
  digit_idx_t      d_q;
  logic [1:0][5:0] snap_q;   // [0] = seconds, [1] = minutes
  logic [6:0]      seg_q;
  logic [3:0]      an_q;
  logic            dp_q;

  logic [1:0][2:0] tens;
  logic [1:0][3:0] ones;
  logic [1:0]      invalid;

  for (genvar gi = 0; gi < 2; gi++) begin : g_conv
    bin60_to_bcd u_conv (
      .value_i   (snap_q[gi]),
      .tens_o    (tens[gi]),
      .ones_o    (ones[gi]),
      .invalid_o (invalid[gi])
    );
  end

  logic       field;
  logic [3:0] digit_val;
  logic [6:0] seg_raw;
  logic [3:0] an_raw;
  logic       dp_raw;
  logic [6:0] seg_d;
  logic [3:0] an_d;
  logic       dp_d;

  // d[1] picks the field, d[0] picks tens over ones.
  always_comb begin
    field     = d_q[1];
    digit_val = d_q[0] ? {1'b0, tens[field]} : ones[field];
    if (invalid[field]) begin
      digit_val = DIGIT_DASH;
    end
    seg_raw = SEG_BLANK;
    an_raw  = 4'h0;
    dp_raw  = 1'b0;
    // rc==0 is a blank slot so the previous digit's segments never ghost.
    if (rc_q != '0) begin
      seg_raw = seg7_encode(digit_val);
      an_raw  = 4'b0001 << d_q;
      dp_raw  = (d_q == 2'd2) && !snap_q[0][0];
    end
    seg_d = ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d  = ACTIVE_LOW ? ~an_raw  : an_raw;
    dp_d  = ACTIVE_LOW ? ~dp_raw  : dp_raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rc_q   <= '0;
      d_q    <= '0;
      snap_q <= '0;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
      dp_q   <= DP_OFF;
    end else begin
      if (rc_q == RC_LAST) begin
        rc_q <= '0;
        d_q  <= d_q + 2'd1;
        if (d_q == 2'd3) begin
          snap_q <= {minutes, seconds};
        end
      end else begin
        rc_q <= rc_q + RC_W'(1);
      end
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
